// File: rtl/regfile_dumper.sv
// regfile_dumper: debug/trace engine that walks a contiguous (wrapping) range of
// the 32x32 register file through one read port. It streams each word out over a
// valid/ready handshake, tagged with its register address.
// Optional feature: define REGFILE_DUMPER_CSUM_EN to append a running-XOR
// checksum word (Out_Csum=1, Out_Last=1, Out_Addr=0) after the last register.
module regfile_dumper #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Clr_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] First_Addr,
    input  logic [ADDR_W-1:0] Last_Addr,
    input  logic              Abort,
    output logic [ADDR_W-1:0] Rd_Addr,
    input  logic [DATA_W-1:0] Rd_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic [ADDR_W-1:0] Out_Addr,
    output logic              Out_Last,
    output logic              Out_Csum,
    output logic              Busy,
    output logic              Done
);

`ifdef REGFILE_DUMPER_CSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_CSUM} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;          // address counter
    logic [ADDR_W-1:0] end_q, end_d;          // latched last address
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              at_end;
`ifdef REGFILE_DUMPER_CSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              out_csum_q, out_csum_d;
`endif

    assign at_end = (cnt_q == end_q);

    // Next-state and registered-output logic; Abort always wins over a handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        end_d       = end_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
`ifdef REGFILE_DUMPER_CSUM_EN
        csum_d      = csum_q;
        out_csum_d  = out_csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start && !Abort) begin
                    cnt_d   = First_Addr;
                    end_d   = Last_Addr;
`ifdef REGFILE_DUMPER_CSUM_EN
                    csum_d  = '0;
`endif
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (Abort) begin
                    state_d = S_IDLE;
                end else begin
                    out_data_d  = Rd_Data;
                    out_addr_d  = cnt_q;
                    out_valid_d = 1'b1;
`ifdef REGFILE_DUMPER_CSUM_EN
                    csum_d      = csum_q ^ Rd_Data;
                    out_csum_d  = 1'b0;
                    out_last_d  = 1'b0;   // the checksum word carries Last
`else
                    out_last_d  = at_end;
`endif
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (Abort) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (Out_Ready) begin
                    out_valid_d = 1'b0;
                    if (at_end) begin
`ifdef REGFILE_DUMPER_CSUM_EN
                        out_data_d  = csum_q;
                        out_addr_d  = '0;
                        out_last_d  = 1'b1;
                        out_csum_d  = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = S_CSUM;
`else
                        done_d      = 1'b1;
                        state_d     = S_IDLE;
`endif
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);   // wraps 31 -> 0
                        state_d = S_READ;
                    end
                end
            end
`ifdef REGFILE_DUMPER_CSUM_EN
            S_CSUM: begin
                if (Abort) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (Out_Ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
`endif
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by Clr_n.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            end_q       <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef REGFILE_DUMPER_CSUM_EN
            csum_q      <= '0;
            out_csum_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            end_q       <= end_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
`ifdef REGFILE_DUMPER_CSUM_EN
            csum_q      <= csum_d;
            out_csum_q  <= out_csum_d;
`endif
        end
    end

    assign Rd_Addr   = (state_q == S_IDLE) ? '0 : cnt_q;
    assign Out_Valid = out_valid_q;
    assign Out_Data  = out_data_q;
    assign Out_Addr  = out_addr_q;
    assign Out_Last  = out_last_q;
    assign Busy      = (state_q != S_IDLE);
    assign Done      = done_q;
`ifdef REGFILE_DUMPER_CSUM_EN
    assign Out_Csum  = out_csum_q;
`else
    assign Out_Csum  = 1'b0;
`endif

endmodule
